// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - game-round controller: show, aim, judge, result, game over
module round_sequencer #(
    parameter int SHOW_TICKS   = 20,
    parameter int AIM_TICKS    = 200,
    parameter int RESULT_TICKS = 10,
    parameter int MAX_MISSES   = 3,
    parameter int SCORE_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic               fire,
    input  logic [4:0]         shot_x,
    input  logic [4:0]         shot_y,
    input  logic [4:0]         target_x,
    input  logic [4:0]         target_y,
    output logic               result_valid,
    output logic               show_target,
    output logic               aim_active,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         misses,
    output logic               game_over,
    output logic [2:0]         state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SHOW   = 3'd1;
    localparam logic [2:0] S_AIM    = 3'd2;
    localparam logic [2:0] S_JUDGE  = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;
    localparam logic [2:0] S_OVER   = 3'd5;

    localparam int MAX_SA = (SHOW_TICKS > AIM_TICKS) ? SHOW_TICKS : AIM_TICKS;
    localparam int MAX_T  = (MAX_SA > RESULT_TICKS) ? MAX_SA : RESULT_TICKS;
    localparam int CNT_W  = $clog2(MAX_T + 1);

    // Each phase ends on the tick that brings the count up to its length.
    localparam logic [CNT_W-1:0]   SHOW_LAST   = CNT_W'(SHOW_TICKS - 1);
    localparam logic [CNT_W-1:0]   AIM_LAST    = CNT_W'(AIM_TICKS - 1);
    localparam logic [CNT_W-1:0]   RESULT_LAST = CNT_W'(RESULT_TICKS - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;
    localparam logic [3:0]         MISS_LIMIT  = 4'(MAX_MISSES);

    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             counting;
    logic             rv_nxt;
    logic             clear_game;
    logic             fired_q;
    logic [4:0]       shot_x_q;
    logic [4:0]       shot_y_q;
    logic             hit_flag_q;
    logic             judge_hit;

    assign counting  = (state == S_SHOW) || (state == S_AIM) || (state == S_RESULT);
    assign judge_hit = fired_q && (shot_x_q == target_x) && (shot_y_q == target_y);

    // Next-state decision, plus the round-start pulse and game-clear strobes.
    always_comb begin
        state_nxt  = state;
        rv_nxt     = 1'b0;
        clear_game = 1'b0;
        case (state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_nxt  = S_SHOW;
                    rv_nxt     = 1'b1;
                    clear_game = 1'b1;
                end
            end
            S_SHOW: begin
                if (tick && cnt_q == SHOW_LAST) state_nxt = S_AIM;
            end
            S_AIM: begin
                // A shot in the same cycle as the timeout tick still counts as fired.
                if (fire || (tick && cnt_q == AIM_LAST)) state_nxt = S_JUDGE;
            end
            S_JUDGE: state_nxt = S_RESULT;
            S_RESULT: begin
                if (tick && cnt_q == RESULT_LAST) begin
                    if (misses == MISS_LIMIT) begin
                        state_nxt = S_OVER;
                    end else begin
                        state_nxt = S_SHOW;
                        rv_nxt    = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register and phase tick counter, cleared on every transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) cnt_q <= '0;
            else if (tick && counting) cnt_q <= cnt_q + 1'b1;
        end
    end

    // Registered one-cycle pulse that advances the target generator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) result_valid <= 1'b0;
        else       result_valid <= rv_nxt;
    end

    // Latch the shot when leaving AIM; a timeout leaves the fired flag clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fired_q  <= 1'b0;
            shot_x_q <= '0;
            shot_y_q <= '0;
        end else if (state == S_AIM && state_nxt == S_JUDGE) begin
            fired_q <= fire;
            if (fire) begin
                shot_x_q <= shot_x;
                shot_y_q <= shot_y;
            end
        end
    end

    // Judge the round against the current target and update score or misses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score      <= '0;
            misses     <= '0;
            hit_flag_q <= 1'b0;
        end else if (clear_game) begin
            score  <= '0;
            misses <= '0;
        end else if (state == S_JUDGE) begin
            hit_flag_q <= judge_hit;
            if (judge_hit) begin
                if (score != SCORE_MAX) score <= score + 1'b1;
            end else begin
                misses <= misses + 4'd1;
            end
        end
    end

    assign show_target = (state == S_SHOW);
    assign aim_active  = (state == S_AIM);
    assign game_over   = (state == S_OVER);
    assign hit         = (state == S_RESULT) && hit_flag_q;
    assign miss        = (state == S_RESULT) && !hit_flag_q;

endmodule

// File: tb/tb_round_sequencer.sv
// tb/tb_round_sequencer.sv - scoreboard bench for round_sequencer
module tb_round_sequencer;

    localparam int MAXM = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       start;
    logic       fire;
    logic [4:0] shot_x;
    logic [4:0] shot_y;
    logic [4:0] target_x;
    logic [4:0] target_y;

    logic       result_valid, show_target, aim_active, hit, miss, game_over;
    logic [7:0] score;
    logic [3:0] misses;
    logic [2:0] state;

    logic       rv_s, show_s, aim_s, hit_s, miss_s, over_s;
    logic [1:0] score_s;
    logic [3:0] misses_s;
    logic [2:0] state_s;

    round_sequencer #(.SHOW_TICKS(2), .AIM_TICKS(4), .RESULT_TICKS(1), .MAX_MISSES(MAXM), .SCORE_W(8)) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .fire(fire),
        .shot_x(shot_x), .shot_y(shot_y), .target_x(target_x), .target_y(target_y),
        .result_valid(result_valid), .show_target(show_target), .aim_active(aim_active),
        .hit(hit), .miss(miss), .score(score), .misses(misses), .game_over(game_over), .state(state)
    );

    round_sequencer #(.SHOW_TICKS(2), .AIM_TICKS(4), .RESULT_TICKS(1), .MAX_MISSES(MAXM), .SCORE_W(2)) dut_s (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .fire(fire),
        .shot_x(shot_x), .shot_y(shot_y), .target_x(target_x), .target_y(target_y),
        .result_valid(rv_s), .show_target(show_s), .aim_active(aim_s),
        .hit(hit_s), .miss(miss_s), .score(score_s), .misses(misses_s), .game_over(over_s), .state(state_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       h;
        logic [7:0] sc;
        logic [1:0] scs;
        logic [3:0] ms;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int   m_score, m_score_s, m_misses;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] stat();
        return {result_valid, show_target, aim_active, game_over, state};
    endfunction

    function automatic logic [6:0] exp_stat(input logic rv, input logic [2:0] st);
        return {rv, st == 3'd1, st == 3'd2, st == 3'd5, st};
    endfunction

    function automatic logic [20:0] all_out();
        return {result_valid, show_target, aim_active, hit, miss, game_over, score, misses, state};
    endfunction

    function automatic logic [14:0] all_out_s();
        return {rv_s, show_s, aim_s, hit_s, miss_s, over_s, score_s, misses_s, state_s};
    endfunction

    // Monitor: pops one expectation each time a result is presented.
    logic prev_hm = 1'b0;
    logic prev_rv = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if ((hit || miss) && !prev_hm) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("res_hit", {hit, miss}, {e.h, !e.h});
                    chk("res_score", score, e.sc);
                    chk("res_misses", misses, e.ms);
                    chk("res_hit_s", {hit_s, miss_s}, {e.h, !e.h});
                    chk("res_score_s", score_s, e.scs);
                    chk("res_misses_s", misses_s, e.ms);
                end
            end
            if (result_valid) chk("rv_single_cycle", prev_rv, 1'b0);
        end
        prev_hm <= hit || miss;
        prev_rv <= result_valid;
    end

    // Start request from IDLE or OVER; lands on the first SHOW cycle.
    task automatic start_game();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_score = 0; m_score_s = 0; m_misses = 0;
        chk("start_score", score, 8'd0);
        chk("start_misses", misses, 4'd0);
        chk("start_score_s", score_s, 2'd0);
    endtask

    // One round from the first SHOW cycle; fc = AIM cycle of the shot, -1 for none.
    task automatic do_round(input int fc, input logic [4:0] tx, input logic [4:0] ty,
                            input logic [4:0] sx, input logic [4:0] sy, input bit noise);
        bit   fired;
        bit   is_hit;
        exp_t e;
        chk("show_first", stat(), exp_stat(1'b1, 3'd1));
        target_x = tx;
        target_y = ty;
        if (noise) begin
            fire = 1'b1; shot_x = tx; shot_y = ty;
        end
        @(negedge clk);
        fire = 1'b0;
        chk("show_second", stat(), exp_stat(1'b0, 3'd1));
        @(negedge clk);
        fired = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("aim_cycle", stat(), exp_stat(1'b0, 3'd2));
            if (k == fc) begin
                fire = 1'b1; shot_x = sx; shot_y = sy; fired = 1'b1;
            end
            if (noise && k == 1) start = 1'b1;
            @(negedge clk);
            fire = 1'b0;
            start = 1'b0;
            shot_x = 5'($urandom_range(0, 31));
            shot_y = 5'($urandom_range(0, 31));
            if (fired) break;
        end
        is_hit = fired && (sx == tx) && (sy == ty);
        if (is_hit) begin
            if (m_score < 255) m_score++;
            if (m_score_s < 3) m_score_s++;
        end else begin
            m_misses++;
        end
        e.h = is_hit; e.sc = 8'(m_score); e.scs = 2'(m_score_s); e.ms = 4'(m_misses);
        sb.push_back(e);
        chk("judge", stat(), exp_stat(1'b0, 3'd3));
        @(negedge clk);
        chk("result", stat(), exp_stat(1'b0, 3'd4));
        @(negedge clk);
        if (m_misses == MAXM) begin
            chk("over_entry", stat(), exp_stat(1'b0, 3'd5));
            @(negedge clk);
            chk("over_hold", stat(), exp_stat(1'b0, 3'd5));
            chk("over_score", score, 8'(m_score));
            chk("over_misses", misses, 4'(MAXM));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] tx, ty, sx, sy;
        int fc, b, r;
        reset = 1'b1; tick = 1'b1; start = 1'b0; fire = 1'b0;
        shot_x = '0; shot_y = '0; target_x = '0; target_y = '0;
        m_score = 0; m_score_s = 0; m_misses = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_out(), 21'd0);
        chk("reset_outputs_s", all_out_s(), 15'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle", stat(), exp_stat(1'b0, 3'd0));

        // Directed game: hits, wrong coordinate, late fire, ignores, saturation of narrow score.
        start_game();
        do_round(0, 5'd7, 5'd1, 5'd7, 5'd1, 1'b0);
        do_round(0, 5'd7, 5'd1, 5'd7, 5'd0, 1'b0);
        do_round(3, 5'd12, 5'd30, 5'd12, 5'd30, 1'b0);
        do_round(1, 5'd3, 5'd9, 5'd3, 5'd9, 1'b1);
        do_round(2, 5'd31, 5'd0, 5'd31, 5'd0, 1'b0);
        do_round(0, 5'd0, 5'd31, 5'd0, 5'd31, 1'b1);
        do_round(-1, 5'd5, 5'd5, 5'd5, 5'd5, 1'b0);
        do_round(2, 5'd5, 5'd5, 5'd4, 5'd5, 1'b0);

        // Restart from OVER and end by three timeouts.
        start_game();
        for (int i = 0; i < 3; i++) do_round(-1, 5'd9, 5'd9, 5'd9, 5'd9, 1'b0);

        // Reset between clock edges in the middle of AIM.
        start_game();
        chk("rst_show", stat(), exp_stat(1'b1, 3'd1));
        @(negedge clk);
        @(negedge clk);
        chk("rst_aim", stat(), exp_stat(1'b0, 3'd2));
        #2 reset = 1'b1;
        #1;
        chk("async_reset", all_out(), 21'd0);
        chk("async_reset_s", all_out_s(), 15'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", stat(), exp_stat(1'b0, 3'd0));
        start_game();
        do_round(0, 5'd7, 5'd1, 5'd7, 5'd1, 1'b0);

        // Finish that game with random rounds, then several fully random games.
        for (int g = 0; g < 6; g++) begin
            if (g > 0) start_game();
            r = 0;
            while (m_misses < MAXM) begin
                tx = 5'($urandom_range(0, 31));
                ty = 5'($urandom_range(0, 31));
                sx = tx; sy = ty;
                if ($urandom_range(0, 1) == 0) begin
                    b = $urandom_range(0, 9);
                    if (b < 5) sx[b] = ~sx[b];
                    else       sy[b-5] = ~sy[b-5];
                end
                fc = $urandom_range(0, 4);
                if (fc == 4 || r >= 20) fc = -1;
                do_round(fc, tx, ty, sx, sy, 1'($urandom_range(0, 1)));
                r++;
            end
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
